// File: rtl/fetch_align_buffer.sv
// Fetch align buffer: halfword queue that turns fetch beats into
// aligned 16/32-bit instructions for decode.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   clear, clear_offset flush; first halfword index of next beat
//   fetch_valid/pc/rdata/error  incoming fetch beat
//   fetch_stall         registered back-pressure, beat dropped while 1
//   instr_valid/ready   head handshake towards decode
//   instr_pc/instr/instr_comp/instr_error  head instruction
module fetch_align_buffer #(
   parameter int FETCH_HW = 2,
   parameter int DEPTH    = 16,
   localparam int OW      = (FETCH_HW > 2) ? $clog2(FETCH_HW) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [OW-1:0]         clear_offset,
   input  logic                  fetch_valid,
   input  logic [31:0]           fetch_pc,
   input  logic [16*FETCH_HW-1:0] fetch_rdata,
   input  logic                  fetch_error,
   output logic                  fetch_stall,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           instr_pc,
   output logic [31:0]           instr,
   output logic                  instr_comp,
   output logic                  instr_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   hw_q  [DEPTH];
   logic [31:0]   pc_q  [DEPTH];
   logic          err_q [DEPTH];

   logic [AW-1:0] wid_q;
   logic [AW-1:0] rid_q;
   logic [AW-1:0] rid1;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_nx;
   logic [CW-1:0] push_n;
   logic [CW-1:0] pop_n;
   logic [CW-1:0] free_nx;
   logic          first_q;
   logic [OW-1:0] off_q;
   logic [OW-1:0] start;
   logic          stall_q;
   logic          accept;
   logic          pop;

   logic [AW-1:0] widx [FETCH_HW];
   logic          wen  [FETCH_HW];

   logic [15:0]   h0_hw;
   logic [15:0]   h1_hw;
   logic [31:0]   h0_pc;
   logic          h0_err;
   logic          h1_err;
   logic          h0_comp;
   logic          has1;
   logic          has2;

   logic          hd_valid;
   logic          hd_err;
   logic          hd_comp;
   logic [31:0]   hd_instr;
   logic [31:0]   hd_pc;
   logic [CW-1:0] hd_len;

   // Push side: the first beat after a clear skips the halfwords
   // below clear_offset; the rest are packed at consecutive slots.
   always_comb begin
      start  = first_q ? off_q : '0;
      accept = fetch_valid && !stall_q && !clear;
      push_n = accept ? (CW'(FETCH_HW) - CW'(start)) : '0;
      for (int k = 0; k < FETCH_HW; k++) begin
         wen[k]  = accept && (k >= int'(start));
         widx[k] = wid_q + AW'(k) - AW'(start);
      end
   end

   // Head decode works only from registered state.
   always_comb begin
      rid1    = rid_q + AW'(1);
      h0_hw   = hw_q[rid_q];
      h0_pc   = pc_q[rid_q];
      h0_err  = err_q[rid_q];
      h1_hw   = hw_q[rid1];
      h1_err  = err_q[rid1];
      h0_comp = (h0_hw[1:0] != 2'b11);
      has1    = (count_q != '0);
      has2    = (count_q >= CW'(2));
   end

   always_comb begin
      hd_valid = 1'b0;
      hd_err   = 1'b0;
      hd_comp  = 1'b0;
      hd_instr = '0;
      hd_pc    = '0;
      hd_len   = '0;
      if (has1 && h0_err) begin
         // Faulted first halfword is reported alone so a
         // following good beat is not swallowed.
         hd_valid = 1'b1;
         hd_err   = 1'b1;
         hd_comp  = 1'b1;
         hd_pc    = h0_pc;
         hd_len   = CW'(1);
      end else if (has1 && h0_comp) begin
         hd_valid = 1'b1;
         hd_comp  = 1'b1;
         hd_instr = {16'h0000, h0_hw};
         hd_pc    = h0_pc;
         hd_len   = CW'(1);
      end else if (has2 && h1_err) begin
         hd_valid = 1'b1;
         hd_err   = 1'b1;
         hd_pc    = h0_pc;
         hd_len   = CW'(2);
      end else if (has2) begin
         hd_valid = 1'b1;
         hd_instr = {h1_hw, h0_hw};
         hd_pc    = h0_pc;
         hd_len   = CW'(2);
      end
   end

   always_comb begin
      pop      = hd_valid && instr_ready && !clear;
      pop_n    = pop ? hd_len : '0;
      count_nx = count_q + push_n - pop_n;
      free_nx  = CW'(DEPTH) - count_nx;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
         wid_q   <= '0;
         rid_q   <= '0;
         first_q <= 1'b0;
         off_q   <= '0;
         stall_q <= 1'b0;
      end else if (clear) begin
         count_q <= '0;
         wid_q   <= '0;
         rid_q   <= '0;
         first_q <= 1'b1;
         off_q   <= clear_offset;
         stall_q <= 1'b0;
      end else begin
         count_q <= count_nx;
         wid_q   <= wid_q + AW'(push_n);
         rid_q   <= rid_q + AW'(pop_n);
         // Stall ahead of time so a full beat always fits.
         stall_q <= (free_nx < CW'(FETCH_HW));
         if (accept) begin
            first_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < FETCH_HW; k++) begin
         if (wen[k]) begin
            hw_q[widx[k]]  <= fetch_rdata[16*k +: 16];
            pc_q[widx[k]]  <= fetch_pc + 32'(2 * k);
            err_q[widx[k]] <= fetch_error;
         end
      end
   end

   assign fetch_stall = stall_q;
   assign instr_valid = hd_valid;
   assign instr_pc    = hd_pc;
   assign instr       = hd_instr;
   assign instr_comp  = hd_comp;
   assign instr_error = hd_err;

endmodule
